// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: NOP encoding,
// FSM state encoding, default reset vector and the fetch address check.
package fetch_unit_pkg;

    // addi x0, x0, 0 -- the canonical RISC-V NOP
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_t;

    // A fetch address is illegal when it is not word aligned or lies past the
    // last whole word of instruction memory. The compare is done on the
    // unwrapped pc, so it fires before pc+4 could ever wrap past 2^32.
    function automatic logic pc_is_bad(input logic [31:0] pc,
                                       input logic [31:0] last_pc);
        return (pc[1:0] != 2'b00) || (pc > last_pc);
    endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Output register of the fetch stage: holds the fetched word, its pc and
// pc+4, plus the valid flag. Flush has priority over load; otherwise hold.
module fetch_out_reg
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4
);

    // Capture a new word on load, drop validity on flush, else hold everything.
    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= NOP_INST;
            out_pc    <= 32'h0000_0000;
            out_pc4   <= 32'h0000_0000;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_inst  <= inst;
            out_pc    <= pc;
            out_pc4   <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-stage instruction fetch: pc register, RUN/FAULT control, accepted
// handshake counter and the fetch output register. One word per cycle while
// downstream is ready; redirects flush the output and win over everything.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned MEM_NBYTE = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc4,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] LAST_PC = 32'(MEM_NBYTE - 4);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         load;
    logic         flush;
    logic         take_fault;
    logic         handshake;

    assign imem_addr = pc;
    assign handshake = out_valid && out_ready;

    // Decide this cycle's action: redirect, load the word at pc, or fault on it.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        load       = 1'b0;
        flush      = 1'b0;
        take_fault = 1'b0;
        if (redirect_valid) begin
            flush = 1'b1;
        end else if (state == ST_RUN && (!out_valid || out_ready)) begin
            if (pc_is_bad(pc, LAST_PC)) begin
                take_fault = 1'b1;
                flush      = 1'b1;
            end else begin
                load = 1'b1;
            end
        end
    end

    // Control FSM with the pc and the sticky fault registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            pc       <= RESET_PC;
            fault    <= 1'b0;
            fault_pc <= 32'h0000_0000;
        end else if (redirect_valid) begin
            // A redirect is the only way out of FAULT; an illegal target is
            // accepted here and trips the check on the next load attempt.
            state <= ST_RUN;
            pc    <= redirect_pc;
            fault <= 1'b0;
        end else if (take_fault) begin
            state    <= ST_FAULT;
            fault    <= 1'b1;
            fault_pc <= pc;
        end else if (load) begin
            pc <= pc + 32'd4;
        end
    end

    // Count accepted words, including one accepted in a redirect cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'h0000_0000;
        end else if (handshake) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    fetch_out_reg u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .flush     (flush),
        .inst      (imem_inst),
        .pc        (pc),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_pc4   (out_pc4)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 4 KiB instance for sequencing, stall,
// redirect and fault behaviour, and a 16-byte instance for the end-of-memory
// fault and reset out of FAULT. Memory word at byte address p holds A000_0000|p.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] mem [0:1023];

    // Instance A: default 4 KiB memory
    logic [31:0] a_imem_addr, a_imem_inst, a_redirect_pc;
    logic        a_redirect_valid, a_out_ready, a_out_valid, a_fault;
    logic [31:0] a_out_inst, a_out_pc, a_out_pc4, a_fault_pc, a_fetch_count;

    // Instance B: 16-byte memory
    logic [31:0] b_imem_addr, b_imem_inst, b_redirect_pc;
    logic        b_redirect_valid, b_out_ready, b_out_valid, b_fault;
    logic [31:0] b_out_inst, b_out_pc, b_out_pc4, b_fault_pc, b_fetch_count;

    always #5 clk = ~clk;

    assign a_imem_inst = (a_imem_addr < 32'h1000 && a_imem_addr[1:0] == 2'b00)
                         ? mem[a_imem_addr[11:2]] : 32'hDEAD_BEEF;
    assign b_imem_inst = (b_imem_addr < 32'h1000 && b_imem_addr[1:0] == 2'b00)
                         ? mem[b_imem_addr[11:2]] : 32'hDEAD_BEEF;

    fetch_unit dut_a (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(a_imem_addr), .imem_inst(a_imem_inst),
        .redirect_valid(a_redirect_valid), .redirect_pc(a_redirect_pc),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_inst(a_out_inst), .out_pc(a_out_pc), .out_pc4(a_out_pc4),
        .fault(a_fault), .fault_pc(a_fault_pc), .fetch_count(a_fetch_count)
    );

    fetch_unit #(.MEM_NBYTE(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(b_imem_addr), .imem_inst(b_imem_inst),
        .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_inst(b_out_inst), .out_pc(b_out_pc), .out_pc4(b_out_pc4),
        .fault(b_fault), .fault_pc(b_fault_pc), .fetch_count(b_fetch_count)
    );

    function automatic logic [31:0] word_at(input logic [31:0] p);
        return 32'hA000_0000 | p;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        a_redirect_valid = 1'b0; a_redirect_pc = 32'h0; a_out_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_out_valid, a_out_inst, a_out_pc, a_out_pc4} !== {1'b0, 32'h13, 32'h0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_out: got v=%b i=%h pc=%h pc4=%h want v=0 i=00000013 pc=0 pc4=0",
                     a_out_valid, a_out_inst, a_out_pc, a_out_pc4);
        end
        n_cmp++;
        if ({a_imem_addr, a_fault, a_fault_pc, a_fetch_count} !== {32'h0, 1'b0, 32'h0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_state: got addr=%h f=%b fpc=%h cnt=%0d want 0/0/0/0",
                     a_imem_addr, a_fault, a_fault_pc, a_fetch_count);
        end
        @(negedge clk);
        n_cmp++;
        if ({a_out_valid, a_imem_addr} !== {1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_held: got v=%b addr=%h want v=0 addr=0", a_out_valid, a_imem_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential_stall();
        logic [31:0] p;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            p = 32'(4 * k);
            n_cmp++;
            if ({a_out_valid, a_out_pc, a_out_inst, a_out_pc4, a_fetch_count} !==
                {1'b1, p, word_at(p), p + 32'd4, 32'(k)}) begin
                n_bad++;
                $display("FAIL seq k=%0d: got v=%b pc=%h i=%h pc4=%h cnt=%0d want pc=%h cnt=%0d",
                         k, a_out_valid, a_out_pc, a_out_inst, a_out_pc4, a_fetch_count, p, k);
            end
        end
        a_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({a_out_valid, a_out_pc, a_out_inst, a_imem_addr, a_fetch_count} !==
                {1'b1, 32'h8, word_at(32'h8), 32'hC, 32'd2}) begin
                n_bad++;
                $display("FAIL stall c=%0d: got v=%b pc=%h i=%h addr=%h cnt=%0d want pc=8 addr=c cnt=2",
                         k, a_out_valid, a_out_pc, a_out_inst, a_imem_addr, a_fetch_count);
            end
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a_out_valid, a_out_pc, a_out_inst, a_fetch_count} !== {1'b1, 32'hC, word_at(32'hC), 32'd3}) begin
            n_bad++;
            $display("FAIL resume: got v=%b pc=%h i=%h cnt=%0d want pc=c cnt=3",
                     a_out_valid, a_out_pc, a_out_inst, a_fetch_count);
        end
        @(negedge clk);
        n_cmp++;
        if ({a_out_pc, a_fetch_count} !== {32'h10, 32'd4}) begin
            n_bad++;
            $display("FAIL four_accepts: got pc=%h cnt=%0d want pc=10 cnt=4", a_out_pc, a_fetch_count);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (3) @(negedge clk);
        a_out_ready = 1'b0;
        @(negedge clk);
        a_redirect_valid = 1'b1; a_redirect_pc = 32'h40;
        @(negedge clk);
        n_cmp++;
        if ({a_out_valid, a_imem_addr, a_fetch_count} !== {1'b0, 32'h40, 32'd2}) begin
            n_bad++;
            $display("FAIL redir_flush: got v=%b addr=%h cnt=%0d want v=0 addr=40 cnt=2",
                     a_out_valid, a_imem_addr, a_fetch_count);
        end
        a_redirect_valid = 1'b0; a_out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a_out_valid, a_out_pc, a_out_inst, a_fetch_count} !== {1'b1, 32'h40, word_at(32'h40), 32'd2}) begin
            n_bad++;
            $display("FAIL redir_target: got v=%b pc=%h i=%h cnt=%0d want pc=40 cnt=2",
                     a_out_valid, a_out_pc, a_out_inst, a_fetch_count);
        end
        @(negedge clk);
        // Handshake on 0x44 in the same cycle as a redirect to the last legal word
        a_redirect_valid = 1'b1; a_redirect_pc = 32'hFFC;
        @(negedge clk);
        n_cmp++;
        if ({a_out_valid, a_imem_addr, a_fetch_count} !== {1'b0, 32'hFFC, 32'd4}) begin
            n_bad++;
            $display("FAIL redir_handshake: got v=%b addr=%h cnt=%0d want v=0 addr=ffc cnt=4",
                     a_out_valid, a_imem_addr, a_fetch_count);
        end
        a_redirect_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a_out_valid, a_out_pc, a_out_inst, a_out_pc4, a_fault} !==
            {1'b1, 32'hFFC, word_at(32'hFFC), 32'h1000, 1'b0}) begin
            n_bad++;
            $display("FAIL last_word: got v=%b pc=%h i=%h pc4=%h f=%b want pc=ffc pc4=1000 f=0",
                     a_out_valid, a_out_pc, a_out_inst, a_out_pc4, a_fault);
        end
        @(negedge clk);
        n_cmp++;
        if ({a_fault, a_fault_pc, a_out_valid, a_fetch_count} !== {1'b1, 32'h1000, 1'b0, 32'd5}) begin
            n_bad++;
            $display("FAIL range_fault: got f=%b fpc=%h v=%b cnt=%0d want f=1 fpc=1000 v=0 cnt=5",
                     a_fault, a_fault_pc, a_out_valid, a_fetch_count);
        end
    endtask

    task automatic test_fault();
        do_reset();
        @(negedge clk);
        a_redirect_valid = 1'b1; a_redirect_pc = 32'h42;
        @(negedge clk);
        a_redirect_valid = 1'b0;
        n_cmp++;
        if ({a_out_valid, a_fault, a_fetch_count} !== {1'b0, 1'b0, 32'd1}) begin
            n_bad++;
            $display("FAIL misalign_accept: got v=%b f=%b cnt=%0d want v=0 f=0 cnt=1",
                     a_out_valid, a_fault, a_fetch_count);
        end
        @(negedge clk);
        n_cmp++;
        if ({a_fault, a_fault_pc, a_out_valid, a_imem_addr} !== {1'b1, 32'h42, 1'b0, 32'h42}) begin
            n_bad++;
            $display("FAIL misalign_fault: got f=%b fpc=%h v=%b addr=%h want f=1 fpc=42 v=0 addr=42",
                     a_fault, a_fault_pc, a_out_valid, a_imem_addr);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({a_fault, a_out_valid, a_imem_addr, a_fetch_count} !== {1'b1, 1'b0, 32'h42, 32'd1}) begin
            n_bad++;
            $display("FAIL fault_sticky: got f=%b v=%b addr=%h cnt=%0d want f=1 v=0 addr=42 cnt=1",
                     a_fault, a_out_valid, a_imem_addr, a_fetch_count);
        end
        a_redirect_valid = 1'b1; a_redirect_pc = 32'h10;
        @(negedge clk);
        a_redirect_valid = 1'b0;
        n_cmp++;
        if ({a_fault, a_out_valid, a_imem_addr} !== {1'b0, 1'b0, 32'h10}) begin
            n_bad++;
            $display("FAIL fault_exit: got f=%b v=%b addr=%h want f=0 v=0 addr=10",
                     a_fault, a_out_valid, a_imem_addr);
        end
        @(negedge clk);
        n_cmp++;
        if ({a_out_valid, a_out_pc, a_out_inst} !== {1'b1, 32'h10, word_at(32'h10)}) begin
            n_bad++;
            $display("FAIL fault_restart: got v=%b pc=%h i=%h want v=1 pc=10",
                     a_out_valid, a_out_pc, a_out_inst);
        end
        a_redirect_valid = 1'b1; a_redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        a_redirect_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a_fault, a_fault_pc, a_imem_addr, a_out_valid} !== {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0}) begin
            n_bad++;
            $display("FAIL top_fault: got f=%b fpc=%h addr=%h v=%b want f=1 fpc=fffffffc addr=fffffffc v=0",
                     a_fault, a_fault_pc, a_imem_addr, a_out_valid);
        end
    endtask

    task automatic test_small_mem();
        logic [31:0] p;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            p = 32'(4 * k);
            n_cmp++;
            if ({b_out_valid, b_out_pc, b_out_inst, b_fault} !== {1'b1, p, word_at(p), 1'b0}) begin
                n_bad++;
                $display("FAIL small_seq k=%0d: got v=%b pc=%h i=%h f=%b want pc=%h f=0",
                         k, b_out_valid, b_out_pc, b_out_inst, b_fault, p);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({b_fault, b_fault_pc, b_out_valid, b_fetch_count} !== {1'b1, 32'h10, 1'b0, 32'd4}) begin
            n_bad++;
            $display("FAIL small_fault: got f=%b fpc=%h v=%b cnt=%0d want f=1 fpc=10 v=0 cnt=4",
                     b_fault, b_fault_pc, b_out_valid, b_fetch_count);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({b_out_valid, b_out_inst, b_out_pc, b_out_pc4, b_imem_addr} !==
            {1'b0, 32'h13, 32'h0, 32'h0, 32'h0}) begin
            n_bad++;
            $display("FAIL small_rst_out: got v=%b i=%h pc=%h pc4=%h addr=%h want 0/00000013/0/0/0",
                     b_out_valid, b_out_inst, b_out_pc, b_out_pc4, b_imem_addr);
        end
        n_cmp++;
        if ({b_fault, b_fault_pc, b_fetch_count} !== {1'b0, 32'h0, 32'h0}) begin
            n_bad++;
            $display("FAIL small_rst_state: got f=%b fpc=%h cnt=%0d want 0/0/0",
                     b_fault, b_fault_pc, b_fetch_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({b_out_valid, b_out_pc, b_out_inst, b_fault, b_fetch_count} !==
            {1'b1, 32'h0, word_at(32'h0), 1'b0, 32'd0}) begin
            n_bad++;
            $display("FAIL small_restart: got v=%b pc=%h i=%h f=%b cnt=%0d want v=1 pc=0 f=0 cnt=0",
                     b_out_valid, b_out_pc, b_out_inst, b_fault, b_fetch_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(4 * i);
        a_redirect_valid = 1'b0; a_redirect_pc = 32'h0; a_out_ready = 1'b1;
        b_redirect_valid = 1'b0; b_redirect_pc = 32'h0; b_out_ready = 1'b1;
        test_reset();
        test_sequential_stall();
        test_redirect();
        test_fault();
        test_small_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
